// File: rtl/cvxif_commit_scheduler.sv
// In-order commit scheduler for CV-X-IF offloaded instructions.
// Issued instructions wait in a circular buffer until the CPU commits or kills
// them; committed ones are dispatched from the head, killed ones are dropped.
module cvxif_commit_scheduler #(
  parameter int X_ID_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [X_ID_WIDTH-1:0]      issue_id_i,
  input  logic [INSTR_WIDTH-1:0]     issue_instr_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       exec_valid_o,
  input  logic                       exec_ready_i,
  output logic [X_ID_WIDTH-1:0]      exec_id_o,
  output logic [INSTR_WIDTH-1:0]     exec_instr_o,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       commit_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_ISSUED,
    SLOT_COMMITTED,
    SLOT_KILLED
  } slot_state_e;

  slot_state_e            slot_state [DEPTH];
  logic [X_ID_WIDTH-1:0]  slot_id    [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             issue_fire;
  logic             pop;
  logic             match_found;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W-1:0] scan_idx;

  // Ready depends only on the registered occupancy, so a full buffer never
  // accepts an issue in the same cycle a slot drains.
  assign issue_ready_o = (count != CNT_W'(DEPTH));
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign outstanding_o = count;

  // Head leaves on a dispatch handshake, or silently when it was killed.
  assign pop = ((slot_state[head] == SLOT_COMMITTED) & exec_ready_i) |
               (slot_state[head] == SLOT_KILLED);

  // Oldest-first search of slots that are ISSUED at the start of the cycle;
  // the tail slot being written this cycle is still FREE so it cannot match.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (!match_found && (slot_state[scan_idx] == SLOT_ISSUED) &&
          (slot_id[scan_idx] == commit_id_i)) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end

  // Dispatch straight from the head slot; data is zeroed while not valid.
  always_comb begin
    exec_valid_o = (slot_state[head] == SLOT_COMMITTED);
    exec_id_o    = exec_valid_o ? slot_id[head]    : '0;
    exec_instr_o = exec_valid_o ? slot_instr[head] : '0;
  end

  // Control state: slot lifecycle, pointers, occupancy and the error pulse.
  // Issue, commit and pop always touch different slots (tail is FREE, a
  // commit target is ISSUED, the popped head is COMMITTED or KILLED).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH; s++) slot_state[s] <= SLOT_FREE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_err_o <= 1'b0;
    end else begin
      if (issue_fire) begin
        slot_state[tail] <= SLOT_ISSUED;
        tail             <= tail + PTR_W'(1);
      end
      if (commit_valid_i && match_found) begin
        slot_state[match_idx] <= commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
      end
      if (pop) begin
        slot_state[head] <= SLOT_FREE;
        head             <= head + PTR_W'(1);
      end
      case ({issue_fire, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      commit_err_o <= commit_valid_i & ~match_found;
    end
  end

  // Payload storage carries no reset; it is only observed through a slot
  // whose state says it holds a live entry.
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      slot_id[tail]    <= issue_id_i;
      slot_instr[tail] <= issue_instr_i;
    end
  end

endmodule

// File: tb/tb_cvxif_commit_scheduler.sv
// Directed bench for cvxif_commit_scheduler: a vector table for the main
// handshake flows plus hand-written sequences for stall and reset cases.
module tb_cvxif_commit_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [3:0]  issue_id_i = '0;
  logic [31:0] issue_instr_i = '0;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        exec_valid_o;
  logic        exec_ready_i = 1'b0;
  logic [3:0]  exec_id_o;
  logic [31:0] exec_instr_o;
  logic [2:0]  outstanding_o;
  logic        commit_err_o;

  int checks = 0;
  int failures = 0;

  cvxif_commit_scheduler #(
    .X_ID_WIDTH (4),
    .DEPTH      (4),
    .INSTR_WIDTH(32)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_id_i    (issue_id_i),
    .issue_instr_i (issue_instr_i),
    .commit_valid_i(commit_valid_i),
    .commit_id_i   (commit_id_i),
    .commit_kill_i (commit_kill_i),
    .exec_valid_o  (exec_valid_o),
    .exec_ready_i  (exec_ready_i),
    .exec_id_o     (exec_id_o),
    .exec_instr_o  (exec_instr_o),
    .outstanding_o (outstanding_o),
    .commit_err_o  (commit_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [3:0]  iid;
    logic [31:0] iins;
    logic        cv;
    logic [3:0]  cid;
    logic        ck;
    logic        er;
    logic        x_ir;
    logic        x_ev;
    logic [3:0]  x_eid;
    logic [31:0] x_ei;
    logic [2:0]  x_out;
    logic        x_cerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [3:0] iid, input logic [31:0] iins,
                     input logic cv, input logic [3:0] cid, input logic ck, input logic er,
                     input logic x_ir, input logic x_ev, input logic [3:0] x_eid,
                     input logic [31:0] x_ei, input logic [2:0] x_out, input logic x_cerr);
    vec_t v;
    v.iv = iv; v.iid = iid; v.iins = iins; v.cv = cv; v.cid = cid; v.ck = ck; v.er = er;
    v.x_ir = x_ir; v.x_ev = x_ev; v.x_eid = x_eid; v.x_ei = x_ei; v.x_out = x_out;
    v.x_cerr = x_cerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] iid, input logic [31:0] iins,
                       input logic cv, input logic [3:0] cid, input logic ck, input logic er);
    issue_valid_i  = iv;
    issue_id_i     = iid;
    issue_instr_i  = iins;
    commit_valid_i = cv;
    commit_id_i    = cid;
    commit_kill_i  = ck;
    exec_ready_i   = er;
  endtask

  task automatic check_outs(input string nm, input logic ir, input logic ev,
                            input logic [3:0] eid, input logic [31:0] ei,
                            input logic [2:0] out, input logic cerr);
    chk({nm, "_ready"}, 32'(issue_ready_o), 32'(ir));
    chk({nm, "_evalid"}, 32'(exec_valid_o), 32'(ev));
    chk({nm, "_eid"}, 32'(exec_id_o), 32'(eid));
    chk({nm, "_einstr"}, exec_instr_o, ei);
    chk({nm, "_outst"}, 32'(outstanding_o), 32'(out));
    chk({nm, "_cerr"}, 32'(commit_err_o), 32'(cerr));
  endtask

  task automatic expect_after_edge(input string nm, input logic ir, input logic ev,
                                   input logic [3:0] eid, input logic [31:0] ei,
                                   input logic [2:0] out, input logic cerr);
    @(posedge clk_i);
    #1;
    check_outs(nm, ir, ev, eid, ei, out, cerr);
  endtask

  initial begin
    // Inputs: iv iid iins cv cid ck er | expected: ir ev eid ei out cerr
    // Two issues, two commits, back-to-back dispatch.
    add(1, 3, 32'hA, 0, 0, 0, 1,  1, 0, 0, 32'h0, 1, 0);
    add(1, 5, 32'hB, 0, 0, 0, 1,  1, 0, 0, 32'h0, 2, 0);
    add(0, 0, 32'h0, 1, 3, 0, 1,  1, 1, 3, 32'hA, 2, 0);
    add(0, 0, 32'h0, 1, 5, 0, 1,  1, 1, 5, 32'hB, 1, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,  1, 0, 0, 32'h0, 0, 0);
    // Fill to DEPTH, held issue stalls until the cycle after the pop.
    add(1, 1, 32'h11, 0, 0, 0, 1, 1, 0, 0, 32'h0, 1, 0);
    add(1, 2, 32'h22, 0, 0, 0, 1, 1, 0, 0, 32'h0, 2, 0);
    add(1, 3, 32'h33, 0, 0, 0, 1, 1, 0, 0, 32'h0, 3, 0);
    add(1, 4, 32'h44, 0, 0, 0, 1, 0, 0, 0, 32'h0, 4, 0);
    add(1, 6, 32'h66, 1, 1, 0, 1, 0, 1, 1, 32'h11, 4, 0);
    add(1, 6, 32'h66, 0, 0, 0, 1, 1, 0, 0, 32'h0, 3, 0);
    add(1, 6, 32'h66, 0, 0, 0, 1, 0, 0, 0, 32'h0, 4, 0);
    add(0, 0, 32'h0, 1, 2, 0, 1,  0, 1, 2, 32'h22, 4, 0);
    add(0, 0, 32'h0, 1, 3, 0, 1,  1, 1, 3, 32'h33, 3, 0);
    add(0, 0, 32'h0, 1, 4, 0, 1,  1, 1, 4, 32'h44, 2, 0);
    add(0, 0, 32'h0, 1, 6, 0, 1,  1, 1, 6, 32'h66, 1, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,  1, 0, 0, 32'h0, 0, 0);
    // Out-of-order commit/kill, in-order dispatch, killed entry skipped.
    add(1, 1, 32'h1001, 0, 0, 0, 1, 1, 0, 0, 32'h0, 1, 0);
    add(1, 2, 32'h1002, 0, 0, 0, 1, 1, 0, 0, 32'h0, 2, 0);
    add(1, 3, 32'h1003, 0, 0, 0, 1, 1, 0, 0, 32'h0, 3, 0);
    add(0, 0, 32'h0, 1, 3, 0, 1,    1, 0, 0, 32'h0, 3, 0);
    add(0, 0, 32'h0, 1, 2, 1, 1,    1, 0, 0, 32'h0, 3, 0);
    add(0, 0, 32'h0, 1, 1, 0, 1,    1, 1, 1, 32'h1001, 3, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 2, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 1, 3, 32'h1003, 1, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 0, 0);
    // Unmatched commits: empty buffer, same-cycle issue, double commit.
    add(0, 0, 32'h0, 1, 9, 0, 1,    1, 0, 0, 32'h0, 0, 1);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 0, 0);
    add(1, 4, 32'h4444, 1, 4, 0, 1, 1, 0, 0, 32'h0, 1, 1);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 1, 0);
    add(0, 0, 32'h0, 1, 4, 0, 0,    1, 1, 4, 32'h4444, 1, 0);
    add(0, 0, 32'h0, 1, 4, 0, 0,    1, 1, 4, 32'h4444, 1, 1);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 0, 0);
    // Issue and pop in the same cycle keep the count.
    add(1, 8, 32'h88, 0, 0, 0, 1,   1, 0, 0, 32'h0, 1, 0);
    add(0, 0, 32'h0, 1, 8, 0, 0,    1, 1, 8, 32'h88, 1, 0);
    add(1, 9, 32'h99, 0, 0, 0, 1,   1, 0, 0, 32'h0, 1, 0);
    add(0, 0, 32'h0, 1, 9, 0, 0,    1, 1, 9, 32'h99, 1, 0);
    add(0, 0, 32'h0, 0, 0, 0, 1,    1, 0, 0, 32'h0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check_outs("in_reset", 1, 0, 0, 32'h0, 0, 0);
    rst_ni = 1'b1;
    expect_after_edge("post_reset", 1, 0, 0, 32'h0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].iid, vq[i].iins, vq[i].cv, vq[i].cid, vq[i].ck, vq[i].er);
      expect_after_edge($sformatf("row%0d", i), vq[i].x_ir, vq[i].x_ev, vq[i].x_eid,
                        vq[i].x_ei, vq[i].x_out, vq[i].x_cerr);
    end

    // Committed head held stable through five back-pressured cycles.
    drive(1, 7, 32'h77, 0, 0, 0, 0);
    expect_after_edge("t4_issue", 1, 0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 1, 7, 0, 0);
    expect_after_edge("t4_hold0", 1, 1, 7, 32'h77, 1, 0);
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    for (int c = 1; c < 5; c++) begin
      expect_after_edge($sformatf("t4_hold%0d", c), 1, 1, 7, 32'h77, 1, 0);
    end
    drive(0, 0, 32'h0, 0, 0, 0, 1);
    expect_after_edge("t4_pop", 1, 0, 0, 32'h0, 0, 0);

    // Asynchronous reset in the middle of traffic.
    drive(1, 1, 32'hC1, 0, 0, 0, 0);
    expect_after_edge("t6_i1", 1, 0, 0, 32'h0, 1, 0);
    drive(1, 2, 32'hC2, 0, 0, 0, 0);
    expect_after_edge("t6_i2", 1, 0, 0, 32'h0, 2, 0);
    drive(1, 3, 32'hC3, 0, 0, 0, 0);
    expect_after_edge("t6_i3", 1, 0, 0, 32'h0, 3, 0);
    drive(0, 0, 32'h0, 1, 1, 0, 0);
    expect_after_edge("t6_c1", 1, 1, 1, 32'hC1, 3, 0);
    drive(0, 0, 32'h0, 0, 0, 0, 1);
    rst_ni = 1'b0;
    #1;
    check_outs("t6_async", 1, 0, 0, 32'h0, 0, 0);
    #2;
    rst_ni = 1'b1;
    expect_after_edge("t6_after0", 1, 0, 0, 32'h0, 0, 0);
    expect_after_edge("t6_after1", 1, 0, 0, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
